// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_t : sequencer state (RUN / MEM_WAIT)
//   REG_ZERO     : architectural $0, never a real dependency
//   ctrl_bus_t   : bundle of the enable and flush/bubble controls
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_bus_t;

  // Free-running pipeline: everything loads, nothing is squashed.
  localparam ctrl_bus_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0
  };

  // Held in reset: nothing loads, every stage presents a nop.
  localparam ctrl_bus_t CTRL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_bubble: 1'b1
  };

  // lw in EX writes a register the ID instruction reads; $0 is excluded.
  function automatic logic load_use_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
//   master : datapath side, drives hazard sources, receives controls
//   slave  : controller side, receives hazard sources, drives controls
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_j;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_j, ex_mem_read, ex_rt,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_j, ex_mem_read, ex_rt,
           ex_branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for debug event counts.
//   clk, rst : clock, asynchronous active-high reset (clears count)
//   inc      : add one this cycle unless already all-ones
//   count    : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage MIPS pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pipe_hazard_ctrl_if
//              inputs  - ID source regs, jump, EX load/branch, MEM handshake
//              outputs - PC/IF_ID/ID_EX/EX_MEM/MEM_WB enables, IF_ID and
//                        ID_EX flushes, MEM_WB bubble, sticky memory
//                        timeout, saturating stall and flush counts
// Controls are combinational from state and inputs (zero latency).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  ctrl_bus_t ctrl;
  logic      mem_wait;
  logic      load_use;
  logic      wait_inc;

  // Next state, wait tracking and the priority-ordered control decode.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    ctrl          = CTRL_RUN;

    // A MEM_WAIT cycle with mem_ready set is already a release cycle.
    mem_wait = (state_q == MEM_WAIT) ? !bus.mem_ready
                                     : (bus.mem_req && !bus.mem_ready);
    load_use = load_use_hazard(bus.ex_mem_read, bus.ex_rt, bus.id_rs,
                               bus.id_rt, bus.id_uses_rt);
    wait_inc = (state_q == MEM_WAIT) && !bus.mem_ready;

    unique case (state_q)
      RUN:      if (bus.mem_req && !bus.mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ready)                 state_d = RUN;
      default:  state_d = RUN;
    endcase

    if (state_d == RUN) begin
      wait_cnt_d = '0;
    end else if (wait_inc && (wait_cnt_q != WAIT_LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (wait_inc && (wait_cnt_d == WAIT_LIMIT)) begin
      mem_timeout_d = 1'b1;
    end

    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (mem_wait) begin
      // Freeze everything upstream; flushes stay low so a pending
      // branch/jump is still there when memory releases.
      ctrl.pc_en         = 1'b0;
      ctrl.if_id_en      = 1'b0;
      ctrl.id_ex_en      = 1'b0;
      ctrl.ex_mem_en     = 1'b0;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (bus.ex_branch_taken) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Jump in ID is held with the stalled IF_ID and re-evaluated.
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_en    = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end else if (bus.id_j) begin
      ctrl.if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctrl.pc_en),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.if_id_flush || ctrl.id_ex_flush),
    .count (bus.flush_cnt)
  );

  assign bus.pc_en         = ctrl.pc_en;
  assign bus.if_id_en      = ctrl.if_id_en;
  assign bus.id_ex_en      = ctrl.id_ex_en;
  assign bus.ex_mem_en     = ctrl.ex_mem_en;
  assign bus.mem_wb_en     = ctrl.mem_wb_en;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.id_ex_flush   = ctrl.id_ex_flush;
  assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
  assign bus.mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Control vector order everywhere:
// {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble}
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  localparam logic [7:0] C_RUN   = 8'b11111_000;
  localparam logic [7:0] C_LU    = 8'b00111_010;
  localparam logic [7:0] C_BR    = 8'b11111_110;
  localparam logic [7:0] C_JMP   = 8'b11111_100;
  localparam logic [7:0] C_WAIT  = 8'b00001_001;
  localparam logic [7:0] C_RESET = 8'b00000_111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       j;
    logic       mr;
    logic [4:0] ert;
    logic       bt;
    logic       mreq;
    logic       mrdy;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [7:0]  ctrl;
    bit          chk_cnt;
    logic        tmo;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic j, input logic mr, input logic [4:0] ert,
                        input logic bt, input logic mreq, input logic mrdy);
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_uses_rt      = uses_rt;
    bus.id_j            = j;
    bus.ex_mem_read     = mr;
    bus.ex_rt           = ert;
    bus.ex_branch_taken = bt;
    bus.mem_req         = mreq;
    bus.mem_ready       = mrdy;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_ctrl(input string name, input logic [7:0] c);
    exp_t e;
    e.name = name; e.ctrl = c; e.chk_cnt = 1'b0;
    e.tmo = 1'b0; e.stall = '0; e.flush = '0;
    sb.push_back(e);
  endtask

  task automatic push_all(input string name, input logic [7:0] c, input logic tmo,
                          input logic [15:0] stall, input logic [15:0] flush);
    exp_t e;
    e.name = name; e.ctrl = c; e.chk_cnt = 1'b1;
    e.tmo = tmo; e.stall = stall; e.flush = flush;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [7:0] got;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got no entry, required one");
      return;
    end
    e   = sb.pop_front();
    got = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
           bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble};
    n_cmp++;
    if (got !== e.ctrl) begin
      n_bad++;
      $display("FAIL %s ctrl: got %b required %b", e.name, got, e.ctrl);
    end
    if (e.chk_cnt) begin
      n_cmp++;
      if (bus.mem_timeout !== e.tmo) begin
        n_bad++;
        $display("FAIL %s mem_timeout: got %b required %b", e.name, bus.mem_timeout, e.tmo);
      end
      n_cmp++;
      if (bus.stall_cnt !== e.stall) begin
        n_bad++;
        $display("FAIL %s stall_cnt: got %0d required %0d", e.name, bus.stall_cnt, e.stall);
      end
      n_cmp++;
      if (bus.flush_cnt !== e.flush) begin
        n_bad++;
        $display("FAIL %s flush_cnt: got %0d required %0d", e.name, bus.flush_cnt, e.flush);
      end
    end
  endtask

  // Inputs are driven just after a rising edge; compare on the falling edge.
  task automatic cyc();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    #1;
    push_all("reset", C_RESET, 1'b0, 16'd0, 16'd0);
    check_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rs     rt     ur    j     mr    ert    bt    mreq  mrdy  exp
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN};
    vecs[1]  = '{5'd5, 5'd1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[2]  = '{5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[3]  = '{5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_RUN};
    vecs[4]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN};
    vecs[5]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_BR};
    vecs[6]  = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_JMP};
    vecs[7]  = '{5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[8]  = '{5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BR};
    vecs[9]  = '{5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_RUN};
    vecs[10] = '{5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, C_RUN};
    vecs[11] = '{5'd6, 5'd6, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, C_LU};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].j, vecs[i].mr,
             vecs[i].ert, vecs[i].bt, vecs[i].mreq, vecs[i].mrdy);
      push_ctrl($sformatf("vec%0d", i), vecs[i].exp);
      cyc();
    end

    // Load-use: one bubble, then the hazard drops with the lw in MEM.
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    push_all("lu_stall", C_LU, 1'b0, 16'd0, 16'd0);
    cyc();
    idle();
    push_all("lu_after", C_RUN, 1'b0, 16'd1, 16'd1);
    cyc();

    // Branch plus load-use: branch wins, one flush event.
    do_reset();
    set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    push_all("br_lu", C_BR, 1'b0, 16'd0, 16'd0);
    cyc();
    idle();
    push_all("br_lu_after", C_RUN, 1'b0, 16'd0, 16'd1);
    cyc();

    // Memory wait 3 cycles with a taken branch held across it.
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    push_all("mw1", C_WAIT, 1'b0, 16'd0, 16'd0);
    cyc();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    push_all("mw2", C_WAIT, 1'b0, 16'd1, 16'd0);
    cyc();
    push_all("mw3", C_WAIT, 1'b0, 16'd2, 16'd0);
    cyc();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    push_all("mw_release", C_BR, 1'b0, 16'd3, 16'd0);
    cyc();
    idle();
    push_all("mw_after", C_RUN, 1'b0, 16'd3, 16'd1);
    cyc();

    // Timeout with MAX_WAIT=4: six cycles without ready.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      push_all($sformatf("tmo_wait%0d", k), C_WAIT, (k >= 6), 16'(k - 1), 16'd0);
      cyc();
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    push_all("tmo_release", C_RUN, 1'b1, 16'd6, 16'd0);
    cyc();
    idle();
    push_all("tmo_sticky", C_RUN, 1'b1, 16'd6, 16'd0);
    cyc();
    push_all("tmo_sticky2", C_RUN, 1'b1, 16'd6, 16'd0);
    cyc();

    // Reset while in MEM_WAIT, then confirm the FSM came back in RUN.
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    push_all("rmw1", C_WAIT, 1'b0, 16'd0, 16'd0);
    cyc();
    push_all("rmw2", C_WAIT, 1'b0, 16'd1, 16'd0);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    push_all("rmw_async", C_RESET, 1'b0, 16'd0, 16'd0);
    check_now();
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_all("rmw_run", C_RUN, 1'b0, 16'd0, 16'd0);
    cyc();

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It drives the load enables and flush/bubble controls of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves load-use hazards, taken-branch and jump flushes, and multi-cycle data-memory waits. It also keeps saturating stall and flush counters for debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters
- MAX_WAIT, 15, memory-wait cycles after which mem_timeout sets

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, bne, sw)
- id_j  in  1  jump decoded in ID
- ex_mem_read  in  1  instruction in EX is lw
- ex_rt  in  5  destination rt of the lw in EX
- ex_branch_taken  in  1  beq/bne in EX resolved taken
- mem_req  in  1  lw/sw in MEM is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC load enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables
- if_id_flush  out  1  IF_ID loads a nop
- id_ex_flush  out  1  ID_EX loads a nop (control bits zero, nop flag set)
- mem_wb_bubble  out  1  MEM_WB loads a nop instead of MEM results
- mem_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush events

## Operation
- FSM states: RUN, MEM_WAIT.
- RUN with mem_req=1 and mem_ready=0 moves to MEM_WAIT. MEM_WAIT with mem_ready=1 moves to RUN.
- Controls are combinational from state and inputs. They are evaluated in this strict priority:
  1. Memory wait (state MEM_WAIT, or RUN with mem_req=1 and mem_ready=0): pc_en, if_id_en, id_ex_en and ex_mem_en are 0. mem_wb_en=1 and mem_wb_bubble=1. All flushes are 0, so a pending branch or jump is held, not lost.
  2. ex_branch_taken: all enables are 1, if_id_flush=1, id_ex_flush=1. This overrides load-use and jump.
  3. Load-use (ex_mem_read=1, ex_rt≠0, and either ex_rt==id_rs, or ex_rt==id_rt with id_uses_rt=1): pc_en=0, if_id_en=0, id_ex_flush=1, remaining enables 1. A simultaneous id_j is not honoured; the jump re-evaluates next cycle.
  4. id_j: all enables 1, if_id_flush=1.
  5. Otherwise all enables are 1 and all flushes are 0.
- A MEM_WAIT cycle whose mem_ready=1 releases the pipeline in that same cycle. Controls then follow priorities 2–5.
- wait_cnt (internal, 0..MAX_WAIT, saturating) increments each MEM_WAIT cycle without mem_ready and clears on entry to RUN.
- mem_timeout sets when wait_cnt reaches MAX_WAIT. It clears only on rst.
- stall_cnt increments in every cycle where pc_en=0. It saturates at all-ones.
- flush_cnt increments once in every cycle where if_id_flush or id_ex_flush is 1. It saturates at all-ones.
- Register 0 never causes a load-use stall.

## Timing
- While rst is high and asynchronously on its assertion: state=RUN and wait_cnt=0. The enables pc_en, if_id_en, id_ex_en, ex_mem_en and mem_wb_en are all 0. The flush and bubble controls if_id_flush, id_ex_flush and mem_wb_bubble are all 1. mem_timeout=0, stall_cnt=0, flush_cnt=0.
- After rst deasserts, outputs follow the priority rules in the same cycle. Latency from input to control is 0 cycles.
- Load-use inserts exactly one bubble. Next cycle the lw is in MEM, so the hazard drops naturally.
- Memory wait with ready on cycle N+k freezes the pipeline for k cycles. MEM_WB receives k nops.
- rst during MEM_WAIT returns the FSM to RUN immediately. In-flight counters clear.
- Counters and mem_timeout update on the rising clk edge.

## Structure
- Shared package pipe_pkg holds:
  - state typedef ctrl_state_t {RUN, MEM_WAIT}
  - REG_ZERO=5'd0
  - a ctrl_bus_t struct bundling the enable and flush outputs
- One natural sub-module: sat_counter (parameterised width, inc, rst). It is instantiated for stall_cnt and flush_cnt.
- The FSM and priority logic live in the top.

## Test plan
- Load-use: lw with ex_rt=5 in EX, ID has id_rs=5. Required: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle. stall_cnt goes 0→1.
- Load to $0: ex_mem_read=1, ex_rt=0, id_rs=0. Required: no stall, all enables 1.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with a load-use match. Required: if_id_flush=1, id_ex_flush=1, pc_en=1. flush_cnt increments by 1.
- Memory wait: mem_req=1, mem_ready held low 3 cycles, then high. Required: ex_mem_en=0 and mem_wb_bubble=1 for 3 cycles. Release occurs on the ready cycle, with all enables 1. stall_cnt=3.
- Timeout: with MAX_WAIT=4, mem_ready low for 6 cycles. Required: mem_timeout rises at the 4th wait edge and stays 1 after mem_ready, until rst.
- Reset mid-wait: assert rst in MEM_WAIT. Required: enables 0 and flushes 1 immediately, counters 0. After release the FSM is in RUN with all enables 1.
